// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: register enables, bubble controls,
// memory-wait freeze with watchdog, and a saturating stall-cycle counter.
module pipe_stall_ctrl #(
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned TO_W    = 11,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             im_req,
   input  logic             im_ack,
   input  logic             dm_req,
   input  logic             dm_ack,
   input  logic             load_use,
   input  logic             br_taken,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             bus_err,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {StRun, StWait, StErr} state_e;

   state_e            state_q, state_d;
   logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic              im_out_q, dm_out_q;
   logic [CNT_W-1:0]  stall_cnt_q;
   logic              im_busy, dm_busy, mem_busy;

   // An ack in the same cycle as its request never stalls.
   assign im_busy  = (im_req | im_out_q) & ~im_ack;
   assign dm_busy  = (dm_req | dm_out_q) & ~dm_ack;
   assign mem_busy = im_busy | dm_busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StRun;
         wait_cnt_q <= '0;
         im_out_q   <= 1'b0;
         dm_out_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         im_out_q   <= im_ack ? 1'b0 : (im_req ? 1'b1 : im_out_q);
         dm_out_q   <= dm_ack ? 1'b0 : (dm_req ? 1'b1 : dm_out_q);
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      unique case (state_q)
         StRun: begin
            if (mem_busy) begin
               state_d    = StWait;
               wait_cnt_d = TO_W'(1);
            end
         end
         StWait: begin
            if (!mem_busy) begin
               state_d    = StRun;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == TO_W'(TIMEOUT)) begin
               state_d = StErr;
            end else begin
               wait_cnt_d = wait_cnt_q + TO_W'(1);
            end
         end
         StErr:   state_d = StErr;
         default: state_d = StRun;
      endcase
   end

   always_comb begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      if (rst || state_q == StErr || mem_busy) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
         memwb_en = 1'b0;
      end else if (br_taken) begin
         // Redirect squashes the younger instructions, so load_use is moot here.
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (load_use) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end
   end

   assign bus_err = (state_q == StErr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (!memwb_en && stall_cnt_q != {CNT_W{1'b1}}) begin
         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed and randomized bench for pipe_stall_ctrl against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;

   localparam int unsigned TIMEOUT = 4;
   localparam int unsigned TO_W    = 3;
   localparam int unsigned CNT_W   = 3;
   localparam int          CNT_MAX = 7;

   // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, bus_err}
   localparam logic [7:0] OV_RUN   = 8'b11111_00_0;
   localparam logic [7:0] OV_STALL = 8'b00000_00_0;
   localparam logic [7:0] OV_BR    = 8'b11111_11_0;
   localparam logic [7:0] OV_LU    = 8'b00111_01_0;
   localparam logic [7:0] OV_ERR   = 8'b00000_00_1;

   logic clk = 1'b0;
   logic rst, im_req, im_ack, dm_req, dm_ack, load_use, br_taken;
   logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, bus_err;
   logic [CNT_W-1:0] stall_cnt;
   logic [7:0] ov;

   int total  = 0;
   int passed = 0;

   // Model: pending flags, consecutive-busy streak, error flag, stall count.
   bit m_im, m_dm, m_err;
   int m_streak, m_cnt;

   always #5 clk = ~clk;

   pipe_stall_ctrl #(
      .TIMEOUT(TIMEOUT),
      .TO_W   (TO_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .im_req    (im_req),
      .im_ack    (im_ack),
      .dm_req    (dm_req),
      .dm_ack    (dm_ack),
      .load_use  (load_use),
      .br_taken  (br_taken),
      .pc_en     (pc_en),
      .ifid_en   (ifid_en),
      .idex_en   (idex_en),
      .exmem_en  (exmem_en),
      .memwb_en  (memwb_en),
      .ifid_flush(ifid_flush),
      .idex_flush(idex_flush),
      .bus_err   (bus_err),
      .stall_cnt (stall_cnt)
   );

   assign ov = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, bus_err};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic bit model_busy();
      bit ib, db;
      ib = (im_req | m_im) & ~im_ack;
      db = (dm_req | m_dm) & ~dm_ack;
      return ib | db;
   endfunction

   function automatic logic [7:0] model_ov();
      if (rst || m_err || model_busy()) return m_err ? OV_ERR : OV_STALL;
      if (br_taken) return OV_BR;
      if (load_use) return OV_LU;
      return OV_RUN;
   endfunction

   task automatic model_reset();
      m_im = 0; m_dm = 0; m_err = 0; m_streak = 0; m_cnt = 0;
   endtask

   task automatic model_step();
      bit busy;
      logic [7:0] e;
      if (rst) begin
         model_reset();
         return;
      end
      busy = model_busy();
      e = model_ov();
      if (e[3] == 1'b0 && m_cnt < CNT_MAX) m_cnt++;
      if (!m_err) begin
         if (!busy) m_streak = 0;
         else if (m_streak == TIMEOUT) m_err = 1;
         else m_streak++;
      end
      m_im = im_ack ? 1'b0 : (im_req ? 1'b1 : m_im);
      m_dm = dm_ack ? 1'b0 : (dm_req ? 1'b1 : m_dm);
   endtask

   task automatic drive(input logic r, imr, ima, dmr, dma, lu, br);
      @(negedge clk);
      rst = r; im_req = imr; im_ack = ima; dm_req = dmr; dm_ack = dma;
      load_use = lu; br_taken = br;
      if (r) model_reset();
      #1;
      chk("model_outputs", 32'(ov), 32'(model_ov()));
      chk("model_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
   endtask

   task automatic adv();
      @(posedge clk);
      model_step();
   endtask

   initial begin
      rst = 1'b1; im_req = 0; im_ack = 0; dm_req = 0; dm_ack = 0; load_use = 0; br_taken = 0;
      model_reset();

      // T1 reset / idle
      drive(1, 0, 0, 0, 0, 0, 0);
      chk("t1_rst_outputs", 32'(ov), 32'(OV_STALL));
      adv();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("t1_idle_outputs", 32'(ov), 32'(OV_RUN));
      chk("t1_idle_cnt", 32'(stall_cnt), 32'd0);
      adv();

      // T2 DM wait, ack on third cycle
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0, 1, 0, 0, 0);
         chk("t2_dm_stall", 32'(ov), 32'(OV_STALL));
         adv();
      end
      drive(0, 0, 0, 1, 1, 0, 0);
      chk("t2_dm_release", 32'(ov), 32'(OV_RUN));
      adv();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("t2_cnt", 32'(stall_cnt), 32'd2);
      adv();

      // T3 load-use bubble is not a counted stall
      drive(0, 0, 0, 0, 0, 1, 0);
      chk("t3_load_use", 32'(ov), 32'(OV_LU));
      adv();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("t3_cnt", 32'(stall_cnt), 32'd2);
      adv();

      // T4 branch overrides load-use
      drive(0, 0, 0, 0, 0, 1, 1);
      chk("t4_br_lu", 32'(ov), 32'(OV_BR));
      adv();

      // T5 branch held through an IM wait flushes once on release
      for (int i = 0; i < 2; i++) begin
         drive(0, 1, 0, 0, 0, 0, 1);
         chk("t5_im_stall", 32'(ov), 32'(OV_STALL));
         adv();
      end
      drive(0, 1, 1, 0, 0, 0, 1);
      chk("t5_release_flush", 32'(ov), 32'(OV_BR));
      adv();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("t5_after", 32'(ov), 32'(OV_RUN));
      chk("t5_cnt", 32'(stall_cnt), 32'd4);
      adv();

      // T6 watchdog: one RUN cycle plus TIMEOUT WAIT cycles, then ERR
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 1, 0, 0, 0);
         chk("t6_wait", 32'(ov), 32'(OV_STALL));
         adv();
      end
      drive(0, 0, 0, 1, 0, 0, 0);
      chk("t6_err", 32'(ov), 32'(OV_ERR));
      adv();
      drive(0, 0, 0, 0, 1, 1, 1);
      chk("t6_err_sticky", 32'(ov), 32'(OV_ERR));
      chk("t6_cnt_sat", 32'(stall_cnt), 32'd7);
      adv();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("t6_cnt_hold", 32'(stall_cnt), 32'd7);
      adv();
      drive(1, 0, 0, 0, 0, 0, 0);
      chk("t6_rst_err", 32'(bus_err), 32'd0);
      chk("t6_rst_cnt", 32'(stall_cnt), 32'd0);
      adv();

      // Mid-wait reset drops outstanding tracking
      drive(0, 1, 0, 0, 0, 0, 0);
      adv();
      drive(1, 0, 0, 0, 0, 0, 0);
      adv();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("rst_mid_wait", 32'(ov), 32'(OV_RUN));
      adv();

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(99) < 2),
               ($urandom_range(99) < 30), ($urandom_range(99) < 35),
               ($urandom_range(99) < 25), ($urandom_range(99) < 35),
               ($urandom_range(99) < 20), ($urandom_range(99) < 15));
         adv();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
